// File: rtl/mat4x4_4x2_seq_mac.sv
// Sequential signed 4x4 x 4x2 matrix multiply on one time-shared MAC, fed one element per handshake.
// Optional MATMUL_PAR_OUT_EN adds registered parallel outputs S0..S7 and a done pulse.
module mat4x4_4x2_seq_mac #(
  parameter int DATA_W = 5,
  parameter int ACC_W  = 12
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic signed [ACC_W-1:0]  out_data,
  output logic [2:0]               out_idx,
  output logic                     out_last,
  output logic                     out_valid,
  input  logic                     out_ready
`ifdef MATMUL_PAR_OUT_EN
  ,
  output logic signed [ACC_W-1:0]  S0,
  output logic signed [ACC_W-1:0]  S1,
  output logic signed [ACC_W-1:0]  S2,
  output logic signed [ACC_W-1:0]  S3,
  output logic signed [ACC_W-1:0]  S4,
  output logic signed [ACC_W-1:0]  S5,
  output logic signed [ACC_W-1:0]  S6,
  output logic signed [ACC_W-1:0]  S7,
  output logic                     done
`endif
);

  localparam logic [1:0] LOAD_A = 2'd0;
  localparam logic [1:0] LOAD_B = 2'd1;
  localparam logic [1:0] CALC   = 2'd2;
  localparam logic [1:0] OUT    = 2'd3;

  localparam int PW = 2 * DATA_W;

  logic [1:0]               state;
  logic [4:0]               el_cnt;
  logic [2:0]               res_idx;
  logic [1:0]               k;
  logic signed [ACC_W-1:0]  acc;
  logic signed [DATA_W-1:0] elem [24];

  logic [4:0]               a_sel, b_sel;
  logic signed [DATA_W-1:0] a_el, b_el;
  logic signed [PW-1:0]     prod;
  logic signed [ACC_W-1:0]  acc_nxt;

  // A[i][k] lives at 4i+k, B[k][j] at 16+2k+j; result index is 2i+j.
  assign a_sel   = {1'b0, res_idx[2:1], k};
  assign b_sel   = 5'd16 + {2'b00, k, res_idx[0]};
  assign a_el    = elem[a_sel];
  assign b_el    = elem[b_sel];
  assign prod    = PW'(a_el) * PW'(b_el);
  assign acc_nxt = acc + {{(ACC_W-PW){prod[PW-1]}}, prod};

  assign in_ready  = (state == LOAD_A) || (state == LOAD_B);
  assign out_valid = (state == OUT);
  assign out_idx   = res_idx;
  assign out_last  = out_valid && (res_idx == 3'd7);

`ifdef MATMUL_PAR_OUT_EN
  logic signed [ACC_W-1:0] par_s [8];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < 8; n++) par_s[n] <= '0;
    end else if (state == CALC && k == 2'd3) begin
      par_s[res_idx] <= acc_nxt;
    end
  end

  assign S0   = par_s[0];
  assign S1   = par_s[1];
  assign S2   = par_s[2];
  assign S3   = par_s[3];
  assign S4   = par_s[4];
  assign S5   = par_s[5];
  assign S6   = par_s[6];
  assign S7   = par_s[7];
  assign done = out_valid && out_ready && out_last;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= LOAD_A;
      el_cnt   <= '0;
      res_idx  <= '0;
      k        <= '0;
      acc      <= '0;
      out_data <= '0;
      for (int n = 0; n < 24; n++) elem[n] <= '0;
    end else begin
      case (state)
        LOAD_A: begin
          if (in_valid) begin
            elem[el_cnt] <= in_data;
            el_cnt       <= el_cnt + 5'd1;
            if (el_cnt == 5'd15) state <= LOAD_B;
          end
        end
        LOAD_B: begin
          if (in_valid) begin
            elem[el_cnt] <= in_data;
            if (el_cnt == 5'd23) begin
              el_cnt  <= '0;
              res_idx <= '0;
              k       <= '0;
              acc     <= '0;
              state   <= CALC;
            end else begin
              el_cnt <= el_cnt + 5'd1;
            end
          end
        end
        CALC: begin
          acc <= acc_nxt;
          k   <= k + 2'd1;
          if (k == 2'd3) begin
            out_data <= acc_nxt;
            state    <= OUT;
          end
        end
        default: begin
          // Result is held until the consumer takes it; the MAC idles meanwhile.
          if (out_ready) begin
            if (res_idx == 3'd7) begin
              res_idx <= '0;
              state   <= LOAD_A;
            end else begin
              res_idx <= res_idx + 3'd1;
              acc     <= '0;
              k       <= '0;
              state   <= CALC;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mat4x4_4x2_seq_mac.sv
// Scoreboard bench for mat4x4_4x2_seq_mac: expected results queued at load, checked as they stream out.
module tb_mat4x4_4x2_seq_mac;

  logic              clk = 1'b0;
  logic              rst_n;
  logic signed [4:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic signed [11:0] out_data;
  logic [2:0]        out_idx;
  logic              out_last;
  logic              out_valid;
  logic              out_ready;

  mat4x4_4x2_seq_mac dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_idx(out_idx), .out_last(out_last),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic signed [11:0] d;
    logic [2:0]         ix;
    logic               ls;
  } exp_t;

  exp_t exp_q[$];
  int   ma[16];
  int   mb[8];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic logic signed [11:0] ref_s(input int idx);
    int s = 0;
    for (int kk = 0; kk < 4; kk++) s += ma[4*(idx/2)+kk] * mb[2*kk+(idx%2)];
    return 12'(s);
  endfunction

  task automatic send(input logic signed [4:0] d);
    bit got = 1'b0;
    @(negedge clk);
    in_data  = d;
    in_valid = 1'b1;
    for (int t = 0; t < 200; t++) begin
      if (in_ready) begin got = 1'b1; break; end
      @(negedge clk);
    end
    if (!got) begin
      n_checks++; n_fail++;
      $display("FAIL send_timeout: in_ready=0, required 1");
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic load_pair(input bit gaps);
    exp_t e;
    for (int r = 0; r < 8; r++) begin
      e.d = ref_s(r); e.ix = 3'(r); e.ls = (r == 7);
      exp_q.push_back(e);
    end
    for (int n = 0; n < 24; n++) begin
      if (gaps) repeat ($urandom_range(0, 3)) @(posedge clk);
      send(5'(n < 16 ? ma[n] : mb[n-16]));
    end
  endtask

  // Waits for out_valid (sampled on negedge) and returns what the DUT shows; no checking here.
  task automatic get_result(output bit ok, output logic signed [11:0] d,
                            output logic [2:0] ix, output logic ls, output int c);
    ok = 1'b0;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (out_valid) begin ok = 1'b1; break; end
    end
    d = out_data; ix = out_idx; ls = out_last; c = cyc;
  endtask

  task automatic rand_pair();
    for (int n = 0; n < 16; n++) ma[n] = int'($urandom_range(0, 31)) - 16;
    for (int n = 0; n < 8; n++)  mb[n] = int'($urandom_range(0, 31)) - 16;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({out_valid, out_data, out_idx, out_last} !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: valid=%0b data=%0d idx=%0d last=%0b, required all 0",
               out_valid, out_data, out_idx, out_last);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready: got %0b, required 1", in_ready);
    end
  endtask

  task automatic test_ones();
    bit ok; logic signed [11:0] d; logic [2:0] ix; logic ls; int c, c_last;
    exp_t e;
    for (int n = 0; n < 16; n++) ma[n] = 1;
    for (int n = 0; n < 8; n++)  mb[n] = 1;
    load_pair(1'b0);
    c_last = cyc;
    for (int r = 0; r < 8; r++) begin
      get_result(ok, d, ix, ls, c);
      e = exp_q.pop_front();
      n_checks++;
      if (!ok || d !== e.d || ix !== e.ix || ls !== e.ls) begin
        n_fail++;
        $display("FAIL ones_result: ok=%0b data=%0d idx=%0d last=%0b, required data=%0d idx=%0d last=%0b",
                 ok, d, ix, ls, e.d, e.ix, e.ls);
      end
      if (r == 0) begin
        n_checks++;
        if (c - c_last != 4) begin
          n_fail++; $display("FAIL first_latency: got %0d edges, required 4", c - c_last);
        end
      end
    end
  endtask

  task automatic test_corner(input int av, input int bv, input string nm);
    bit ok; logic signed [11:0] d; logic [2:0] ix; logic ls; int c;
    exp_t e;
    for (int n = 0; n < 16; n++) ma[n] = av;
    for (int n = 0; n < 8; n++)  mb[n] = bv;
    load_pair(1'b0);
    for (int r = 0; r < 8; r++) begin
      get_result(ok, d, ix, ls, c);
      e = exp_q.pop_front();
      n_checks++;
      if (!ok || d !== e.d || ix !== e.ix || ls !== e.ls) begin
        n_fail++;
        $display("FAIL %s: ok=%0b data=%0d idx=%0d last=%0b, required data=%0d idx=%0d last=%0b",
                 nm, ok, d, ix, ls, e.d, e.ix, e.ls);
      end
    end
  endtask

  task automatic test_identity();
    bit ok; logic signed [11:0] d; logic [2:0] ix; logic ls; int c;
    int bv[8] = '{1, -2, 3, -4, 5, -6, 7, -8};
    exp_t e;
    for (int n = 0; n < 16; n++) ma[n] = (n / 4 == n % 4) ? 1 : 0;
    for (int n = 0; n < 8; n++)  mb[n] = bv[n];
    load_pair(1'b0);
    for (int r = 0; r < 8; r++) begin
      get_result(ok, d, ix, ls, c);
      e = exp_q.pop_front();
      n_checks++;
      if (!ok || d !== 12'(bv[r]) || d !== e.d || ix !== e.ix || ls !== e.ls) begin
        n_fail++;
        $display("FAIL identity: ok=%0b data=%0d idx=%0d, required data=%0d idx=%0d",
                 ok, d, ix, bv[r], r);
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok; logic signed [11:0] d; logic [2:0] ix; logic ls; int c, c_rel;
    exp_t e;
    rand_pair();
    load_pair(1'b0);
    for (int r = 0; r < 8; r++) begin
      get_result(ok, d, ix, ls, c);
      e = exp_q.pop_front();
      n_checks++;
      if (!ok || d !== e.d || ix !== e.ix || ls !== e.ls) begin
        n_fail++;
        $display("FAIL bp_result: ok=%0b data=%0d idx=%0d last=%0b, required data=%0d idx=%0d last=%0b",
                 ok, d, ix, ls, e.d, e.ix, e.ls);
      end
      if (r == 3) begin
        n_checks++;
        if (c - c_rel != 5) begin
          n_fail++; $display("FAIL bp_resume_latency: got %0d, required 5", c - c_rel);
        end
      end
      if (r == 1) begin
        @(posedge clk);
        #1 out_ready = 1'b0;
      end
      if (r == 2) begin
        repeat (3) begin
          @(negedge clk);
          n_checks++;
          if (out_valid !== 1'b1 || out_data !== d || out_idx !== 3'd2) begin
            n_fail++;
            $display("FAIL bp_hold: valid=%0b data=%0d idx=%0d, required 1 %0d 2",
                     out_valid, out_data, out_idx, d);
          end
        end
        out_ready = 1'b1;
        c_rel = cyc;
      end
    end
  endtask

  task automatic test_gaps();
    bit ok; logic signed [11:0] d; logic [2:0] ix; logic ls; int c;
    exp_t e;
    rand_pair();
    load_pair(1'b1);
    for (int r = 0; r < 8; r++) begin
      get_result(ok, d, ix, ls, c);
      e = exp_q.pop_front();
      n_checks++;
      if (!ok || d !== e.d || ix !== e.ix || ls !== e.ls) begin
        n_fail++;
        $display("FAIL gaps_result: ok=%0b data=%0d idx=%0d, required data=%0d idx=%0d",
                 ok, d, ix, e.d, e.ix);
      end
    end
  endtask

  task automatic test_reset_mid_calc();
    bit ok; logic signed [11:0] d; logic [2:0] ix; logic ls; int c;
    exp_t e;
    rand_pair();
    load_pair(1'b0);
    for (int r = 0; r < 5; r++) begin
      get_result(ok, d, ix, ls, c);
      e = exp_q.pop_front();
      n_checks++;
      if (!ok || d !== e.d || ix !== e.ix) begin
        n_fail++;
        $display("FAIL pre_reset_result: data=%0d idx=%0d, required %0d %0d", d, ix, e.d, e.ix);
      end
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({out_valid, out_data, out_idx, out_last} !== 16'h0) begin
      n_fail++;
      $display("FAIL mid_calc_reset: valid=%0b data=%0d idx=%0d last=%0b, required all 0",
               out_valid, out_data, out_idx, out_last);
    end
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_ready: in_ready=%0b out_valid=%0b, required 1 0", in_ready, out_valid);
    end
    rand_pair();
    load_pair(1'b0);
    for (int r = 0; r < 8; r++) begin
      get_result(ok, d, ix, ls, c);
      e = exp_q.pop_front();
      n_checks++;
      if (!ok || d !== e.d || ix !== e.ix || ls !== e.ls) begin
        n_fail++;
        $display("FAIL reload_result: ok=%0b data=%0d idx=%0d, required data=%0d idx=%0d",
                 ok, d, ix, e.d, e.ix);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit ok; logic signed [11:0] d; logic [2:0] ix; logic ls; int c;
    exp_t e;
    for (int p = 0; p < 2; p++) begin
      rand_pair();
      load_pair(1'b0);
      for (int r = 0; r < 8; r++) begin
        get_result(ok, d, ix, ls, c);
        e = exp_q.pop_front();
        n_checks++;
        if (!ok || d !== e.d || ix !== e.ix || ls !== e.ls) begin
          n_fail++;
          $display("FAIL b2b_result: pair=%0d ok=%0b data=%0d idx=%0d, required data=%0d idx=%0d",
                   p, ok, d, ix, e.d, e.ix);
        end
      end
      @(negedge clk);
      n_checks++;
      if (in_ready !== 1'b1) begin
        n_fail++; $display("FAIL b2b_in_ready: got %0b, required 1", in_ready);
      end
    end
  endtask

  initial begin
    test_reset();
    test_ones();
    test_corner(-16, -16, "neg16_neg16");
    test_corner(-16, 15, "neg16_pos15");
    test_identity();
    test_backpressure();
    test_gaps();
    test_reset_mid_calc();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
